// File: rtl/pixel_ctrl_pkg.sv
// Shared types and helpers for the pixel array frame sequencer.
package pixel_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERASE   = 3'd1,
        EXPOSE  = 3'd2,
        CONVERT = 3'd3,
        READ    = 3'd4,
        GUARD   = 3'd5
    } ctrl_state_t;

    // Phase that a GUARD cycle hands over to.
    typedef enum logic [1:0] {
        NX_EXPOSE  = 2'd0,
        NX_CONVERT = 2'd1,
        NX_READ    = 2'd2,
        NX_END     = 2'd3
    } phase_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pixel_phase_timer.sv
// Loadable down-counter timing every phase of the frame; done while the count is zero.
module pixel_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Count register: load phase length minus one, then count down to zero and hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= len;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a ramp-ADC pixel array: erase/expose/convert/read control, ramp code and row capture.
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int N_ROWS    = 2,
    parameter int N_COLS    = 2,
    parameter int C_ERASE   = 5,
    parameter int C_CONVERT = 255,
    parameter int C_READ    = 5,
    parameter int EXP_W     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_i,
    input  logic                               continuous_i,
    input  logic [EXP_W-1:0]                   expose_len_i,
    output logic                               erase_o,
    output logic                               expose_o,
    output logic                               convert_o,
    output logic [DATA_W-1:0]                  ramp_code_o,
    output logic                               bus_drive_o,
    output logic [N_ROWS-1:0]                  read_o,
    input  logic [N_COLS*DATA_W-1:0]           pix_data_i,
    output logic                               out_valid_o,
    output logic [clog2_min1(N_ROWS)-1:0]      out_row_o,
    output logic [N_COLS*DATA_W-1:0]           out_data_o,
    output logic                               busy_o,
    output logic                               frame_done_o
);

    localparam int ROW_W = clog2_min1(N_ROWS);
    localparam int TW    = max_int(EXP_W, max_int(clog2_min1(C_CONVERT),
                                   max_int(clog2_min1(C_ERASE), clog2_min1(C_READ))));

    localparam logic [TW-1:0]     LEN_ERASE   = TW'(C_ERASE - 1);
    localparam logic [TW-1:0]     LEN_CONVERT = TW'(C_CONVERT - 1);
    localparam logic [TW-1:0]     LEN_READ    = TW'(C_READ - 1);
    localparam logic [DATA_W-1:0] RAMP_MAX    = {DATA_W{1'b1}};
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(N_ROWS - 1);
    localparam logic [N_ROWS-1:0] ROW_ONE     = N_ROWS'(1);

    ctrl_state_t         state_r, state_n;
    phase_t              nxt_r, nxt_n;
    logic [ROW_W-1:0]    row_r, row_n;
    logic [EXP_W-1:0]    exp_r;
    logic [TW-1:0]       exp_len_s;
    logic                latch_exp_s;
    logic                tmr_load_s;
    logic [TW-1:0]       tmr_len_s;
    logic                tmr_done_s;
    logic                cap_s;
    logic                last_row_s;
    logic [DATA_W-1:0]   ramp_n_s;
    logic [N_ROWS-1:0]   read_n_s;
    logic                bus_n_s;

    // A latched exposure of zero still exposes for one cycle.
    assign exp_len_s  = (exp_r == {EXP_W{1'b0}}) ? {TW{1'b0}} : TW'(exp_r - {{(EXP_W-1){1'b0}}, 1'b1});
    assign cap_s      = (state_r == READ) && tmr_done_s;
    assign last_row_s = (row_r == LAST_ROW);

    pixel_phase_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load_s),
        .len   (tmr_len_s),
        .done  (tmr_done_s)
    );

    // Next-state logic: every active phase is followed by one GUARD cycle.
    always_comb begin
        state_n     = state_r;
        nxt_n       = nxt_r;
        row_n       = row_r;
        tmr_load_s  = 1'b0;
        tmr_len_s   = LEN_ERASE;
        latch_exp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_n     = ERASE;
                    tmr_load_s  = 1'b1;
                    latch_exp_s = 1'b1;
                    row_n       = {ROW_W{1'b0}};
                end else begin
                    state_n = IDLE;
                end
            end
            ERASE: begin
                if (tmr_done_s) begin
                    state_n = GUARD;
                    nxt_n   = NX_EXPOSE;
                end else begin
                    state_n = ERASE;
                end
            end
            EXPOSE: begin
                if (tmr_done_s) begin
                    state_n = GUARD;
                    nxt_n   = NX_CONVERT;
                end else begin
                    state_n = EXPOSE;
                end
            end
            CONVERT: begin
                if (tmr_done_s) begin
                    state_n = GUARD;
                    nxt_n   = NX_READ;
                    row_n   = {ROW_W{1'b0}};
                end else begin
                    state_n = CONVERT;
                end
            end
            READ: begin
                if (tmr_done_s) begin
                    state_n = GUARD;
                    if (last_row_s) begin
                        nxt_n = NX_END;
                    end else begin
                        nxt_n = NX_READ;
                        row_n = row_r + {{(ROW_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_n = READ;
                end
            end
            GUARD: begin
                case (nxt_r)
                    NX_EXPOSE: begin
                        state_n    = EXPOSE;
                        tmr_load_s = 1'b1;
                        tmr_len_s  = exp_len_s;
                    end
                    NX_CONVERT: begin
                        state_n    = CONVERT;
                        tmr_load_s = 1'b1;
                        tmr_len_s  = LEN_CONVERT;
                    end
                    NX_READ: begin
                        state_n    = READ;
                        tmr_load_s = 1'b1;
                        tmr_len_s  = LEN_READ;
                    end
                    NX_END: begin
                        if (continuous_i) begin
                            state_n     = ERASE;
                            tmr_load_s  = 1'b1;
                            latch_exp_s = 1'b1;
                            row_n       = {ROW_W{1'b0}};
                        end else begin
                            state_n = IDLE;
                        end
                    end
                    default: begin
                        state_n = IDLE;
                    end
                endcase
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Next values of the registered pixel-side outputs, decoded from the next state.
    always_comb begin
        ramp_n_s = {DATA_W{1'b0}};
        read_n_s = {N_ROWS{1'b0}};
        if (state_n == CONVERT) begin
            if (state_r == CONVERT) begin
                ramp_n_s = (ramp_code_o == RAMP_MAX) ? RAMP_MAX
                                                     : ramp_code_o + {{(DATA_W-1){1'b0}}, 1'b1};
            end else begin
                ramp_n_s = {DATA_W{1'b0}};
            end
        end else begin
            ramp_n_s = {DATA_W{1'b0}};
        end
        if (state_n == READ) begin
            read_n_s = ROW_ONE << row_n;
        end else begin
            read_n_s = {N_ROWS{1'b0}};
        end
        // Release the bus one cycle before any row drives it.
        bus_n_s = !((state_n == READ) || ((state_n == GUARD) && (nxt_n == NX_READ)));
    end

    // FSM, row index and latched exposure length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            nxt_r   <= NX_EXPOSE;
            row_r   <= {ROW_W{1'b0}};
            exp_r   <= {EXP_W{1'b0}};
        end else begin
            state_r <= state_n;
            nxt_r   <= nxt_n;
            row_r   <= row_n;
            if (latch_exp_s) begin
                exp_r <= expose_len_i;
            end
        end
    end

    // Output registers, including the row capture taken on the last read cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            erase_o      <= 1'b0;
            expose_o     <= 1'b0;
            convert_o    <= 1'b0;
            ramp_code_o  <= {DATA_W{1'b0}};
            bus_drive_o  <= 1'b0;
            read_o       <= {N_ROWS{1'b0}};
            out_valid_o  <= 1'b0;
            out_row_o    <= {ROW_W{1'b0}};
            out_data_o   <= {(N_COLS*DATA_W){1'b0}};
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            erase_o      <= (state_n == ERASE);
            expose_o     <= (state_n == EXPOSE);
            convert_o    <= (state_n == CONVERT);
            ramp_code_o  <= ramp_n_s;
            bus_drive_o  <= bus_n_s;
            read_o       <= read_n_s;
            busy_o       <= (state_n != IDLE);
            out_valid_o  <= cap_s;
            frame_done_o <= cap_s && last_row_s;
            if (cap_s) begin
                out_row_o  <= row_r;
                out_data_o <= pix_data_i;
            end
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: frame timing, ramp, readout, continuous mode, exposure and reset abort.
module tb_pixel_array_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        continuous_i = 1'b0;
    logic [15:0] expose_len_i = 16'd255;

    logic        erase_o, expose_o, convert_o, bus_drive_o, out_valid_o, busy_o, frame_done_o;
    logic [7:0]  ramp_code_o;
    logic [1:0]  read_o;
    logic [15:0] pix_data_i, out_data_o;
    logic [0:0]  out_row_o;

    logic        erase2, expose2, convert2, bus2, valid2, busy2, fd2;
    logic [7:0]  ramp2;
    logic [1:0]  read2;
    logic [15:0] pix2, data2;
    logic [0:0]  row2;

    int n_err = 0;
    int n_checks = 0;

    int n_busy, n_busy2, n_erase, n_expose, n_convert, n_read0, n_read1;
    int n_valid, n_fd, n_overlap, n_ramp_off, n_sat2, n_fd_erase, first_row;
    logic [7:0]  ramp_first, ramp_last, ramp_last2;
    logic [15:0] d0, d1;
    logic        prev_fd, prev_conv;

    always #5 clk = ~clk;

    // Pixel model: each row presents its latched codes while selected.
    assign pix_data_i = read_o[0] ? 16'h3412 : (read_o[1] ? 16'h7856 : 16'h0000);
    assign pix2       = read2[0]  ? 16'h3412 : (read2[1]  ? 16'h7856 : 16'h0000);

    pixel_array_ctrl dut (
        .clk(clk), .reset(reset), .start_i(start_i), .continuous_i(continuous_i),
        .expose_len_i(expose_len_i), .erase_o(erase_o), .expose_o(expose_o),
        .convert_o(convert_o), .ramp_code_o(ramp_code_o), .bus_drive_o(bus_drive_o),
        .read_o(read_o), .pix_data_i(pix_data_i), .out_valid_o(out_valid_o),
        .out_row_o(out_row_o), .out_data_o(out_data_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o)
    );

    // Long convert phase so the ramp saturates before the phase ends.
    pixel_array_ctrl #(.C_CONVERT(300)) dut2 (
        .clk(clk), .reset(reset), .start_i(start_i), .continuous_i(continuous_i),
        .expose_len_i(expose_len_i), .erase_o(erase2), .expose_o(expose2),
        .convert_o(convert2), .ramp_code_o(ramp2), .bus_drive_o(bus2),
        .read_o(read2), .pix_data_i(pix2), .out_valid_o(valid2),
        .out_row_o(row2), .out_data_o(data2), .busy_o(busy2),
        .frame_done_o(fd2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks both DUTs until they are idle, gathering per-cycle statistics.
    task automatic run_frame(input int max_cyc, input int clr_at, input int exp_at,
                             input logic [15:0] exp_val, input int start_at);
        int n;
        n = 0;
        n_busy = 0; n_busy2 = 0; n_erase = 0; n_expose = 0; n_convert = 0;
        n_read0 = 0; n_read1 = 0; n_valid = 0; n_fd = 0; n_overlap = 0;
        n_ramp_off = 0; n_sat2 = 0; n_fd_erase = 0; first_row = -1;
        ramp_first = 8'hAA; ramp_last = 8'hAA; ramp_last2 = 8'hAA;
        d0 = 16'h0000; d1 = 16'h0000; prev_fd = 1'b0; prev_conv = 1'b0;
        while ((busy_o || busy2) && n < max_cyc) begin
            if (n == clr_at) continuous_i = 1'b0;
            if (n == exp_at) expose_len_i = exp_val;
            start_i = (n == start_at);
            n_busy += int'(busy_o);
            n_busy2 += int'(busy2);
            n_erase += int'(erase_o);
            n_expose += int'(expose_o);
            n_convert += int'(convert_o);
            n_read0 += int'(read_o[0]);
            n_read1 += int'(read_o[1]);
            if (convert_o && !prev_conv) ramp_first = ramp_code_o;
            if (convert_o) ramp_last = ramp_code_o;
            prev_conv = convert_o;
            if (!convert_o && ramp_code_o != 8'h00) n_ramp_off++;
            if (bus_drive_o && (read_o != 2'b00)) n_overlap++;
            if (out_valid_o) begin
                if (n_valid == 0) first_row = int'(out_row_o);
                n_valid++;
                if (out_row_o == 1'b0) d0 = out_data_o;
                else d1 = out_data_o;
            end
            if (prev_fd && erase_o) n_fd_erase++;
            prev_fd = frame_done_o;
            n_fd += int'(frame_done_o);
            if (convert2 && ramp2 == 8'hFF) n_sat2++;
            if (convert2) ramp_last2 = ramp2;
            n++;
            @(negedge clk);
        end
        start_i = 1'b0;
        chk("frame_bound", 32'(n < max_cyc), 32'd1);
    endtask

    initial begin
        int w;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {26'd0, erase_o, expose_o, convert_o, read_o, out_valid_o}, 32'd0);
        chk("rst_ramp", 32'(ramp_code_o), 32'd0);
        chk("rst_bus", 32'(bus_drive_o), 32'd0);
        chk("rst_data", {15'd0, out_row_o, out_data_o}, 32'd0);
        chk("rst_busy_fd", {30'd0, busy_o, frame_done_o}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_bus", 32'(bus_drive_o), 32'd1);
        chk("idle_busy", 32'(busy_o), 32'd0);

        // Single frame, ramp and readout; a start pulse while busy is ignored
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("start_erase", 32'(erase_o), 32'd1);
        run_frame(3000, -1, -1, 16'd0, 100);
        chk("f1_busy", 32'(n_busy), 32'd530);
        chk("f1_erase", 32'(n_erase), 32'd5);
        chk("f1_expose", 32'(n_expose), 32'd255);
        chk("f1_convert", 32'(n_convert), 32'd255);
        chk("f1_read0", 32'(n_read0), 32'd5);
        chk("f1_read1", 32'(n_read1), 32'd5);
        chk("f1_frame_done", 32'(n_fd), 32'd1);
        chk("f1_valid", 32'(n_valid), 32'd2);
        chk("f1_first_row", 32'(first_row), 32'd0);
        chk("f1_row0_data", 32'(d0), 32'h3412);
        chk("f1_row1_data", 32'(d1), 32'h7856);
        chk("f1_bus_overlap", 32'(n_overlap), 32'd0);
        chk("ramp_first", 32'(ramp_first), 32'd0);
        chk("ramp_last", 32'(ramp_last), 32'd254);
        chk("ramp_outside", 32'(n_ramp_off), 32'd0);
        chk("sat_busy", 32'(n_busy2), 32'd575);
        // Code reaches 255 on convert cycle 256 and holds through cycle 300
        chk("sat_hold", 32'(n_sat2), 32'd45);
        chk("sat_last", 32'(ramp_last2), 32'd255);
        repeat (5) @(negedge clk);
        chk("hold_data", 32'(out_data_o), 32'h7856);
        chk("hold_row", 32'(out_row_o), 32'd1);
        chk("no_restart", {30'd0, busy_o, out_valid_o}, 32'd0);

        // Continuous mode for three frames, cleared during the third
        continuous_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        run_frame(5000, 1200, -1, 16'd0, -1);
        chk("cont_busy", 32'(n_busy), 32'd1590);
        chk("cont_frames", 32'(n_fd), 32'd3);
        chk("cont_erase", 32'(n_erase), 32'd15);
        chk("cont_back2back", 32'(n_fd_erase), 32'd2);
        chk("cont_valid", 32'(n_valid), 32'd6);
        chk("cont_busy_sat", 32'(n_busy2), 32'd1725);
        repeat (5) @(negedge clk);
        chk("cont_stopped", 32'(busy_o), 32'd0);

        // Zero exposure is one cycle
        expose_len_i = 16'd0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        run_frame(3000, -1, -1, 16'd0, -1);
        chk("exp0_expose", 32'(n_expose), 32'd1);
        chk("exp0_busy", 32'(n_busy), 32'd276);

        // Exposure change mid-frame applies at the auto-restart
        expose_len_i = 16'd255;
        continuous_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        run_frame(3000, 600, 100, 16'd10, -1);
        chk("exp_chg_expose", 32'(n_expose), 32'd265);
        chk("exp_chg_busy", 32'(n_busy), 32'd815);
        chk("exp_chg_frames", 32'(n_fd), 32'd2);
        chk("exp_chg_busy_sat", 32'(n_busy2), 32'd905);

        // Reset during CONVERT
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        w = 0;
        while (!convert_o && w < 1000) begin
            w++;
            @(negedge clk);
        end
        chk("reach_convert", 32'(convert_o), 32'd1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstc_ctrl", {26'd0, erase_o, expose_o, convert_o, read_o, busy_o}, 32'd0);
        chk("rstc_ramp", 32'(ramp_code_o), 32'd0);
        chk("rstc_data", {15'd0, out_row_o, out_data_o}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rstc_strobes", {30'd0, out_valid_o, frame_done_o}, 32'd0);
        reset = 1'b0;

        // Reset during READ of row 1
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        w = 0;
        while (!read_o[1] && w < 1000) begin
            w++;
            @(negedge clk);
        end
        chk("reach_read1", 32'(read_o[1]), 32'd1);
        chk("read1_row0_seen", 32'(out_data_o), 32'h3412);
        reset = 1'b1;
        #1;
        chk("rstr_ctrl", {26'd0, read_o, bus_drive_o, out_valid_o, frame_done_o, busy_o}, 32'd0);
        chk("rstr_data", {15'd0, out_row_o, out_data_o}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstr_idle", {30'd0, busy_o, out_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
